// File: rtl/scarv_uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// The frame format (data bits, parity, stop bits), the bit rate and the FIFO depth are
// set by parameters. Bytes arrive over a valid/ready handshake and are sent on uart_txd.
//
// Ports:
//   f_clk      - free running clock
//   g_resetn   - synchronous active-low reset
//   tx_valid   - tx_data holds a byte to queue
//   tx_ready   - FIFO has room; a transfer happens on tx_valid && tx_ready
//   tx_data    - frame payload, bit 0 is sent first
//   uart_txd   - registered serial output, idles high
//   busy       - a frame is in progress or the FIFO holds data
//   fifo_count - number of queued entries
module scarv_uart_tx_fifo #(
  parameter int unsigned UART_BIT_RATE  = 256_000,
  parameter int unsigned UART_CLK_HZ    = 50_000_000,
  parameter int unsigned UART_STOP_BITS = 1,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          f_clk,
  input  logic                          g_resetn,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CYCLES_PER_BIT = UART_CLK_HZ / UART_BIT_RATE;
  localparam int unsigned CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  // Parity values other than odd (1) or even (2) mean no parity bit.
  localparam bit HAS_PARITY = (PARITY == 1) || (PARITY == 2);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(UART_STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // Transmit engine
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 bit_end;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr_q];
  assign head_par   = (PARITY == 1) ? ~(^head) : ^head;
  assign bit_end    = (cnt_q == CNT_LAST);

  assign uart_txd   = txd_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge f_clk) begin
    if (g_resetn && push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    pop     = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
          txd_d   = 1'b0;
          cnt_d   = '0;
          shift_d = head;
          par_d   = head_par;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (HAS_PARITY) begin
              state_d = StParity;
              txd_d   = par_q;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          txd_d   = 1'b1;
          idx_d   = '0;
        end
      end
      StStop: begin
        // idx_q counts stop bits here so two stop bits need no extra counter.
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d = '0;
            if (count_q != '0) begin
              // Chain straight into the next frame with no idle cycle.
              pop     = 1'b1;
              state_d = StStart;
              txd_d   = 1'b0;
              shift_d = head;
              par_d   = head_par;
            end else begin
              state_d = StIdle;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_scarv_uart_tx_fifo.sv
// Self-checking bench for scarv_uart_tx_fifo at 16 clocks per bit.
// Instance 0 is 8N1, instance 1 is 8E1, instance 2 is 8O1, instance 3 is 5E2; all depth 4.
module tb_scarv_uart_tx_fifo;

  localparam int unsigned CPB = 16;
  localparam int unsigned FL  = 160;  // 8N1 frame length in cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [7:0]  data;
  wire  [3:0]  txd, busy, ready;
  wire  [2:0]  cnt0, cnt1, cnt2, cnt3;

  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;
  logic [7:0]  exp_bytes [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scarv_uart_tx_fifo #(
    .UART_BIT_RATE(1), .UART_CLK_HZ(16), .UART_STOP_BITS(1), .DATA_BITS(8), .PARITY(0),
    .FIFO_DEPTH(4)
  ) u_dut (
    .f_clk(clk), .g_resetn(rst_n), .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_data(data),
    .uart_txd(txd[0]), .busy(busy[0]), .fifo_count(cnt0)
  );

  scarv_uart_tx_fifo #(
    .UART_BIT_RATE(1), .UART_CLK_HZ(16), .UART_STOP_BITS(1), .DATA_BITS(8), .PARITY(2),
    .FIFO_DEPTH(4)
  ) u_even (
    .f_clk(clk), .g_resetn(rst_n), .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_data(data),
    .uart_txd(txd[1]), .busy(busy[1]), .fifo_count(cnt1)
  );

  scarv_uart_tx_fifo #(
    .UART_BIT_RATE(1), .UART_CLK_HZ(16), .UART_STOP_BITS(1), .DATA_BITS(8), .PARITY(1),
    .FIFO_DEPTH(4)
  ) u_odd (
    .f_clk(clk), .g_resetn(rst_n), .tx_valid(valid[2]), .tx_ready(ready[2]), .tx_data(data),
    .uart_txd(txd[2]), .busy(busy[2]), .fifo_count(cnt2)
  );

  scarv_uart_tx_fifo #(
    .UART_BIT_RATE(1), .UART_CLK_HZ(16), .UART_STOP_BITS(2), .DATA_BITS(5), .PARITY(2),
    .FIFO_DEPTH(4)
  ) u_5e2 (
    .f_clk(clk), .g_resetn(rst_n), .tx_valid(valid[3]), .tx_ready(ready[3]),
    .tx_data(data[4:0]), .uart_txd(txd[3]), .busy(busy[3]), .fifo_count(cnt3)
  );

  // One frame vector: bits[k] is the expected line level during bit k (k=0 is the start bit),
  // nb is start + data + parity bits, stop_cyc the expected stop length in cycles.
  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  d;
    logic [3:0]  nb;
    logic [15:0] bits;
    logic [5:0]  stop_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_to(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Offers d to instance sel until accepted; acc is the cycle of the accepting edge.
  task automatic push(input int unsigned sel, input logic [7:0] d, output int unsigned acc);
    bit done;
    done = 1'b0;
    acc  = cyc;
    data = d;
    valid[sel] = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (ready[sel]) begin
        @(posedge clk);
        #1;
        acc  = cyc;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    valid[sel] = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  // Decodes n back-to-back 8N1 frames on instance 0, the first starting at edge s0.
  task automatic check_frames(input int unsigned s0, input int unsigned n);
    logic [7:0] b;
    for (int k = 0; k < int'(n); k++) begin
      int unsigned s;
      s = s0 + FL * k;
      wait_to(s - 1);
      chk($sformatf("pre_start_high[%0d]", k), 32'(txd[0]), 32'd1);
      wait_to(s);
      chk($sformatf("start_edge_low[%0d]", k), 32'(txd[0]), 32'd0);
      b = '0;
      for (int bi = 0; bi < 8; bi++) begin
        wait_to(s + CPB * (bi + 1) + CPB / 2);
        b[bi] = txd[0];
      end
      chk($sformatf("frame_byte[%0d]", k), 32'(b), 32'(exp_bytes[k]));
      wait_to(s + 9 * CPB + CPB / 2);
      chk($sformatf("stop_high[%0d]", k), 32'(txd[0]), 32'd1);
    end
    wait_to(s0 + FL * n - 1);
    chk("busy_last_stop", 32'(busy[0]), 32'd1);
    wait_to(s0 + FL * n);
    chk("busy_after_frames", 32'(busy[0]), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned p, a, e, s;
    vec_t v;

    // bits = {parity, data, start 0}, written out by hand.
    vecs[0] = '{sel: 2'd0, d: 8'h55, nb: 4'd9,  bits: 16'h00AA, stop_cyc: 6'd16};
    vecs[1] = '{sel: 2'd0, d: 8'hA3, nb: 4'd9,  bits: 16'h0146, stop_cyc: 6'd16};
    vecs[2] = '{sel: 2'd1, d: 8'h07, nb: 4'd10, bits: 16'h020E, stop_cyc: 6'd16};
    vecs[3] = '{sel: 2'd2, d: 8'h07, nb: 4'd10, bits: 16'h000E, stop_cyc: 6'd16};
    vecs[4] = '{sel: 2'd3, d: 8'h1F, nb: 4'd7,  bits: 16'h007E, stop_cyc: 6'd32};
    vecs[5] = '{sel: 2'd1, d: 8'h00, nb: 4'd10, bits: 16'h0000, stop_cyc: 6'd16};
    vecs[6] = '{sel: 2'd2, d: 8'h00, nb: 4'd10, bits: 16'h0200, stop_cyc: 6'd16};

    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(txd), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(ready), 32'hF);
    chk("rst_count0", 32'(cnt0), 32'd0);
    chk("rst_count_others", 32'({cnt1, cnt2, cnt3}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames from idle across formats.
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      push(int'(v.sel), v.d, p);
      chk($sformatf("v%0d_idle_at_push", i), 32'(txd[v.sel]), 32'd1);
      wait_to(p + 1);
      chk($sformatf("v%0d_start_latency", i), 32'(txd[v.sel]), 32'd0);
      for (int k = 0; k < int'(v.nb); k++) begin
        wait_to(p + 1 + CPB * k + CPB / 2);
        chk($sformatf("v%0d_bit%0d", i, k), 32'(txd[v.sel]), 32'(v.bits[k]));
      end
      e = p + 1 + CPB * v.nb;
      for (int k = 0; k < int'(v.stop_cyc) / int'(CPB); k++) begin
        wait_to(e + CPB * k + CPB / 2);
        chk($sformatf("v%0d_stop%0d", i, k), 32'(txd[v.sel]), 32'd1);
      end
      wait_to(e + v.stop_cyc - 1);
      chk($sformatf("v%0d_busy_in_stop", i), 32'(busy[v.sel]), 32'd1);
      wait_to(e + v.stop_cyc);
      chk($sformatf("v%0d_busy_idle", i), 32'(busy[v.sel]), 32'd0);
      chk($sformatf("v%0d_txd_idle", i), 32'(txd[v.sel]), 32'd1);
      repeat (3) @(negedge clk);
    end

    // Fill the FIFO, hold a sixth push, and decode six back-to-back frames.
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h55; exp_bytes[5] = 8'h66;
    push(0, exp_bytes[0], p);
    fork
      begin
        for (int i = 1; i < 5; i++) push(0, exp_bytes[i], a);
        chk("full_count", 32'(cnt0), 32'd4);
        chk("full_ready", 32'(ready[0]), 32'd0);
        wait_to(p + FL);
        chk("held_ready", 32'(ready[0]), 32'd0);
        push(0, exp_bytes[5], a);
        chk("held_accept_cycle", a, p + FL + 2);
      end
      check_frames(p + 1, 6);
    join
    repeat (3) @(negedge clk);

    // Push on the same edge as the STOP->START pop with two entries queued.
    exp_bytes[0] = 8'h3C; exp_bytes[1] = 8'h81; exp_bytes[2] = 8'hF0; exp_bytes[3] = 8'h0F;
    push(0, exp_bytes[0], p);
    fork
      begin
        push(0, exp_bytes[1], a);
        push(0, exp_bytes[2], a);
        chk("simul_count_before", 32'(cnt0), 32'd2);
        wait_to(p + FL);
        chk("simul_count_pre_edge", 32'(cnt0), 32'd2);
        push(0, exp_bytes[3], a);
        chk("simul_accept_cycle", a, p + FL + 1);
        chk("simul_count_after", 32'(cnt0), 32'd2);
      end
      check_frames(p + 1, 4);
    join
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of a frame with two bytes queued.
    push(0, 8'h00, p);
    push(0, 8'hC3, a);
    push(0, 8'h3C, a);
    s = p + 1;
    wait_to(s + 4 * CPB + 6);
    chk("pre_reset_txd_low", 32'(txd[0]), 32'd0);
    chk("pre_reset_count", 32'(cnt0), 32'd2);
    rst_n = 1'b0;
    wait_to(s + 4 * CPB + 7);
    chk("mid_reset_txd", 32'(txd[0]), 32'd1);
    chk("mid_reset_count", 32'(cnt0), 32'd0);
    chk("mid_reset_busy", 32'(busy[0]), 32'd0);
    chk("mid_reset_ready", 32'(ready[0]), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_bytes[0] = 8'hA5;
    push(0, exp_bytes[0], p);
    check_frames(p + 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
